uart_tx_sched: RTL and testbench

//   Shares one UART transmit line between two requesters (port 0, port 1).

---
 rtl/uart_tx_sched.sv | 132 +++++++++++++
 tb/tb_uart_tx_sched.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_sched.sv
// Purpose: shares one 8N1 UART tx line between two requesters with round-robin arbitration.
// Latency: a req sampled in IDLE gives ack and the start-bit falling edge one cycle later; a frame lasts (DATA_W+2)*CLKS_PER_BIT cycles.
// Backpressure: requests are not queued; the requester holds req until its ack, and req is ignored while a frame is in flight.
module uart_tx_sched #(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 88
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic [DATA_W-1:0] data0,
    output logic              ack0,
    input  logic              req1,
    input  logic [DATA_W-1:0] data1,
    output logic              ack1,
    output logic              tx,
    output logic              busy,
    output logic              owner
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_W - 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] START = 2'd1;
    localparam logic [1:0] DATA  = 2'd2;
    localparam logic [1:0] STOP  = 2'd3;

    logic [1:0]        state;
    logic [CW-1:0]     cnt;
    logic [BW-1:0]     bit_idx;
    logic [DATA_W-1:0] shreg;
    logic              ptr;      // 0: port 0 wins a tie, 1: port 1 wins a tie
    logic              grant0;
    logic              grant1;
    logic              cnt_last;

    assign cnt_last = (cnt == CNT_LAST);
    assign busy     = (state != IDLE);

    // Tie-break between simultaneous requests using the round-robin pointer.
    always_comb begin
        grant0 = req0 && (!req1 || !ptr);
        grant1 = req1 && (!req0 || ptr);
    end

    // Arbitration side effects of a grant: one-cycle ack, owner record, pointer handoff.
    always_ff @(posedge clk) begin
        if (rst) begin
            ack0  <= 1'b0;
            ack1  <= 1'b0;
            owner <= 1'b0;
            ptr   <= 1'b0;
        end else begin
            ack0 <= 1'b0;
            ack1 <= 1'b0;
            if (state == IDLE && (grant0 || grant1)) begin
                ack0  <= grant0;
                ack1  <= grant1;
                owner <= grant1;
                ptr   <= ~grant1;
            end
        end
    end

    // Frame sequencer and serialiser: start bit, DATA_W bits LSB first, stop bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
            tx      <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    cnt     <= '0;
                    bit_idx <= '0;
                    tx      <= 1'b1;
                    if (grant0 || grant1) begin
                        // Byte is captured here; later data changes cannot reach the line.
                        shreg <= grant1 ? data1 : data0;
                        tx    <= 1'b0;
                        state <= START;
                    end
                end
                START: begin
                    if (cnt_last) begin
                        cnt     <= '0;
                        bit_idx <= '0;
                        tx      <= shreg[0];
                        shreg   <= shreg >> 1;
                        state   <= DATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (cnt_last) begin
                        cnt <= '0;
                        if (bit_idx == BIT_LAST) begin
                            tx    <= 1'b1;
                            state <= STOP;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                            tx      <= shreg[0];
                            shreg   <= shreg >> 1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (cnt_last) begin
                        cnt   <= '0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    cnt   <= '0;
                    tx    <= 1'b1;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Randomised and directed stimulus for uart_tx_sched against a cycle-timed frame model.
// Expected acks are queued by the model at each grant edge; a negedge monitor pops and compares.
// The tx line, busy and owner are compared every cycle against the model's current frame.
module tb_uart_tx_sched;

    localparam int DATA_W = 8;
    localparam int CPB    = 88;
    localparam int FRAME  = (DATA_W + 2) * CPB;

    logic              clk = 1'b0;
    logic              rst;
    logic              req0, req1;
    logic [DATA_W-1:0] data0, data1;
    logic              ack0, ack1, tx, busy, owner;

    uart_tx_sched #(.DATA_W(DATA_W), .CLKS_PER_BIT(CPB)) dut (
        .clk   (clk),
        .rst   (rst),
        .req0  (req0),
        .data0 (data0),
        .ack0  (ack0),
        .req1  (req1),
        .data1 (data1),
        .ack1  (ack1),
        .tx    (tx),
        .busy  (busy),
        .owner (owner)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    typedef struct {
        int port;
        int edge_c;
    } exp_t;
    exp_t expq[$];

    // Reference model state
    bit                m_valid   = 1'b0;
    bit                m_active  = 1'b0;
    int                m_fstart  = 0;
    logic [DATA_W-1:0] m_fdata   = '0;
    int                m_owner   = 0;
    int                m_ptr     = 0;
    int                m_next_ok = 0;
    int                m_g;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, got, exp);
        end
    endtask

    // Model: sample inputs at each edge, decide grants, track the frame in flight.
    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            m_valid   = 1'b1;
            m_active  = 1'b0;
            m_ptr     = 0;
            m_owner   = 0;
            m_next_ok = cyc + 1;
            expq.delete();
        end else if (m_valid) begin
            if (m_active && (cyc - m_fstart) >= FRAME) m_active = 1'b0;
            if (cyc >= m_next_ok) begin
                m_g = -1;
                if (req0 && req1) m_g = m_ptr;
                else if (req0)    m_g = 0;
                else if (req1)    m_g = 1;
                if (m_g >= 0) begin
                    exp_t it;
                    m_active  = 1'b1;
                    m_fstart  = cyc;
                    m_fdata   = (m_g == 1) ? data1 : data0;
                    m_owner   = m_g;
                    m_ptr     = 1 - m_g;
                    m_next_ok = cyc + FRAME + 1;
                    it.port   = m_g;
                    it.edge_c = cyc;
                    expq.push_back(it);
                end
            end
        end
    end

    // Monitor: compare DUT outputs against the model away from the active edge.
    logic mon_ea0, mon_ea1, mon_tx;
    int   mon_bit;
    always @(negedge clk) begin
        if (m_valid) begin
            mon_ea0 = 1'b0;
            mon_ea1 = 1'b0;
            if (expq.size() > 0 && (ack0 || ack1 || expq[0].edge_c <= cyc)) begin
                if (expq[0].edge_c == cyc) begin
                    if (expq[0].port == 1) mon_ea1 = 1'b1;
                    else                   mon_ea0 = 1'b1;
                end
                expq.pop_front();
            end
            check("ack0", ack0, mon_ea0);
            check("ack1", ack1, mon_ea1);
            mon_tx = 1'b1;
            if (m_active) begin
                mon_bit = (cyc - m_fstart) / CPB;
                if (mon_bit == 0)           mon_tx = 1'b0;
                else if (mon_bit <= DATA_W) mon_tx = m_fdata[mon_bit-1];
            end
            check("tx", tx, mon_tx);
            check("busy", busy, m_active);
            check("owner", owner, m_owner[0]);
        end
    end

    task automatic wait_ack(output int port, output int at, input int maxc);
        port = -1;
        at   = -1;
        for (int i = 0; i < maxc; i++) begin
            @(negedge clk);
            if (ack0 || ack1) begin
                port = ack1 ? 1 : 0;
                at   = cyc;
                return;
            end
        end
        vectors++;
        miscompares++;
        $display("FAIL ack_timeout at cycle %0d: got no ack within %0d cycles, expected one", cyc, maxc);
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    logic exp_bits [10];
    int   p, t0, t1;
    logic [DATA_W-1:0] d;

    initial begin
        rst = 1'b1; req0 = 1'b0; req1 = 1'b0; data0 = '0; data1 = '0;
        exp_bits = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

        // 1: reset for two cycles, then quiet idle
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        check("t1_idle_tx", tx, 1'b1);
        check("t1_idle_busy", busy, 1'b0);

        // 2: single port-0 frame, mid-bit samples against the literal bit pattern of 8'hA5
        data0 = 8'hA5;
        req0  = 1'b1;
        wait_ack(p, t0, 10);
        req0 = 1'b0;
        check("t2_port", p, 0);
        repeat (CPB / 2) @(negedge clk);
        for (int k = 0; k < 10; k++) begin
            check("t2_bit", tx, exp_bits[k]);
            repeat (CPB) @(negedge clk);
        end
        check("t2_done_busy", busy, 1'b0);

        // 3: simultaneous requests after reset; port 0 first, port 1 one idle cycle later
        pulse_reset();
        data0 = 8'h55; data1 = 8'h0F;
        req0 = 1'b1; req1 = 1'b1;
        wait_ack(p, t0, 10);
        req0 = 1'b0;
        check("t3_first_port", p, 0);
        wait_ack(p, t1, FRAME + 10);
        req1 = 1'b0;
        check("t3_second_port", p, 1);
        check("t3_spacing", t1 - t0, FRAME + 1);
        repeat (FRAME + 10) @(negedge clk);

        // 4: both held continuously, grants alternate with fixed spacing
        pulse_reset();
        req0 = 1'b1; req1 = 1'b1;
        t0 = -1;
        for (int i = 0; i < 4; i++) begin
            wait_ack(p, t1, FRAME + 10);
            check("t4_port", p, i % 2);
            if (i > 0) check("t4_spacing", t1 - t0, FRAME + 1);
            t0 = t1;
        end
        req0 = 1'b0; req1 = 1'b0;
        repeat (FRAME + 10) @(negedge clk);

        // 5: reset in data bit 3 aborts the frame; a fresh frame then completes
        pulse_reset();
        d     = DATA_W'($urandom);
        data0 = d;
        req0  = 1'b1;
        wait_ack(p, t0, 10);
        req0 = 1'b0;
        repeat (4 * CPB + 20) @(negedge clk);
        check("t5_bit3", tx, d[3]);
        pulse_reset();
        check("t5_abort_tx", tx, 1'b1);
        check("t5_abort_busy", busy, 1'b0);
        check("t5_abort_ack", {ack1, ack0}, 2'b00);
        repeat (5) @(negedge clk);
        data0 = DATA_W'($urandom);
        req0  = 1'b1;
        wait_ack(p, t0, 10);
        req0 = 1'b0;
        check("t5_port", p, 0);
        repeat (FRAME + 10) @(negedge clk);

        // 6: back-to-back port-1 frames, then data1 changed mid-frame
        data1 = DATA_W'($urandom);
        req1  = 1'b1;
        wait_ack(p, t0, 10);
        data1 = DATA_W'($urandom);
        wait_ack(p, t1, FRAME + 10);
        req1 = 1'b0;
        check("t6_port", p, 1);
        check("t6_spacing", t1 - t0, FRAME + 1);
        repeat (FRAME + 10) @(negedge clk);
        d     = DATA_W'($urandom);
        data1 = d;
        req1  = 1'b1;
        wait_ack(p, t0, 10);
        req1 = 1'b0;
        repeat (300) @(negedge clk);
        data1 = ~d;
        repeat (FRAME) @(negedge clk);

        // Random phase: sporadic requests, churning data, rare resets
        for (int i = 0; i < 15000; i++) begin
            @(negedge clk);
            if ($urandom_range(3) == 0) req0 = 1'($urandom);
            if ($urandom_range(3) == 0) req1 = 1'($urandom);
            data0 = DATA_W'($urandom);
            data1 = DATA_W'($urandom);
            rst   = ($urandom_range(2499) == 0);
        end
        rst = 1'b0; req0 = 1'b0; req1 = 1'b0;
        repeat (FRAME + 10) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
